// File: rtl/port_rd_pkg.sv
`default_nettype none
// ============================================================================
// Module   : port_rd_pkg
// Brief    : Shared types and constants for the per-port SRAM read matcher.
// Revision : 1.0 - initial release
// ============================================================================
package port_rd_pkg;

   localparam int SRAM_NUM    = 32;
   localparam int SRAM_IDX_W  = 5;
   localparam int AMT_W       = 9;
   localparam int GNT_TIMEOUT = 15;
   localparam int TO_W        = 4;
   localparam int TICK_W      = 5;

   localparam logic [SRAM_IDX_W:0] NO_SRAM = 6'd32;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SCAN = 3'd1,
      ST_REQ  = 3'd2,
      ST_READ = 3'd3,
      ST_FIN  = 3'd4
   } state_t;

   // Distance of idx strictly after last, modulo SRAM_NUM; last itself is the farthest.
   function automatic logic [SRAM_IDX_W-1:0] rr_dist(input logic [SRAM_IDX_W-1:0] idx,
                                                     input logic [SRAM_IDX_W-1:0] last);
      rr_dist = idx - last - 5'd1;
   endfunction

endpackage
`default_nettype wire

// File: rtl/port_rd_best_tracker.sv
`default_nettype none
// ============================================================================
// Module   : port_rd_best_tracker
// Brief    : Qualifies scanned SRAMs and keeps the best (largest queue) choice.
//            PORT_RD_RR_TIEBREAK_EN: equal amounts resolved round-robin.
// Revision : 1.0 - initial release
// ============================================================================
module port_rd_best_tracker
   import port_rd_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  i_clear,
   input  logic                  i_capture_en,
   input  logic                  i_serve,
   input  logic                  i_scan_valid,
   input  logic                  i_scan_readable,
   input  logic [SRAM_IDX_W-1:0] i_scan_sram,
   input  logic [AMT_W-1:0]      i_scan_amount,
   output logic [SRAM_IDX_W:0]   o_best_idx,
   output logic                  o_found
);

   logic [AMT_W-1:0]    r_best_amt;
   logic [SRAM_IDX_W:0] r_best_idx;
   logic                w_tie_wins;
   logic                w_cand;

`ifdef PORT_RD_RR_TIEBREAK_EN
   logic [SRAM_IDX_W-1:0] r_last;

   assign w_tie_wins = rr_dist(i_scan_sram, r_last) < rr_dist(r_best_idx[SRAM_IDX_W-1:0], r_last);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last <= 5'd31;
      end else if (i_serve) begin
         r_last <= r_best_idx[SRAM_IDX_W-1:0];
      end
   end
`else
   logic w_unused_serve;

   assign w_tie_wins     = 1'b1;
   assign w_unused_serve = i_serve;
`endif

   assign w_cand = i_scan_valid && i_scan_readable && (i_scan_amount != '0) &&
                   ((i_scan_amount > r_best_amt) ||
                    ((i_scan_amount == r_best_amt) && w_tie_wins));

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_best_amt <= '0;
         r_best_idx <= NO_SRAM;
      end else if (i_clear) begin
         r_best_amt <= '0;
         r_best_idx <= NO_SRAM;
      end else if (i_capture_en && w_cand) begin
         r_best_amt <= i_scan_amount;
         r_best_idx <= {1'b0, i_scan_sram};
      end
   end

   assign o_best_idx = r_best_idx;
   assign o_found    = !r_best_idx[SRAM_IDX_W];

endmodule
`default_nettype wire

// File: rtl/port_rd_sram_matcher.sv
`default_nettype none
// ============================================================================
// Module   : port_rd_sram_matcher
// Brief    : Per-port read matcher: scan SRAMs, request a read slot, hold it
//            until the packet drains, pulse completion. Optional macro:
//            PORT_RD_RR_TIEBREAK_EN (round-robin tie-break in the tracker).
// Revision : 1.0 - initial release
// ============================================================================
module port_rd_sram_matcher
   import port_rd_pkg::*;
(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [TICK_W-1:0]     match_threshold,
   input  logic                  rd_enable,
   output logic                  rd_finish,
   input  logic [SRAM_IDX_W-1:0] scan_sram,
   input  logic                  scan_valid,
   input  logic                  scan_readable,
   input  logic [AMT_W-1:0]      scan_packet_amount,
   output logic [SRAM_IDX_W:0]   rd_sram,
   output logic                  rd_req,
   input  logic                  rd_gnt,
   output logic                  rd_busy,
   input  logic                  rd_done
);

   state_t            r_state;
   logic [TICK_W-1:0] r_tick;
   logic [TO_W-1:0]   r_to_cnt;
   logic              r_rd_req;
   logic              r_rd_busy;
   logic              r_rd_finish;

   logic              w_found;
   logic              w_commit;
   logic              w_timeout;
   logic              w_clear;
   logic              w_capture;
   logic              w_serve;

   assign w_commit  = (r_state == ST_SCAN) && rd_enable && w_found && (r_tick == match_threshold);
   assign w_timeout = (r_to_cnt == TO_W'(GNT_TIMEOUT - 1));
   // The commit cycle's own candidate is dropped so the requested SRAM is the one decided on.
   assign w_capture = (r_state == ST_SCAN) && rd_enable && !w_commit;
   assign w_serve   = (r_state == ST_READ) && rd_done;

   always_comb begin
      w_clear = 1'b0;
      case (r_state)
         ST_IDLE: w_clear = 1'b1;
         ST_SCAN: w_clear = !rd_enable;
         ST_REQ:  w_clear = !rd_gnt && (!rd_enable || w_timeout);
         ST_READ: w_clear = rd_done;
         ST_FIN:  w_clear = 1'b1;
         default: w_clear = 1'b1;
      endcase
   end

   port_rd_best_tracker u_tracker (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_clear         (w_clear),
      .i_capture_en    (w_capture),
      .i_serve         (w_serve),
      .i_scan_valid    (scan_valid),
      .i_scan_readable (scan_readable),
      .i_scan_sram     (scan_sram),
      .i_scan_amount   (scan_packet_amount),
      .o_best_idx      (rd_sram),
      .o_found         (w_found)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= ST_IDLE;
         r_tick      <= '0;
         r_to_cnt    <= '0;
         r_rd_req    <= 1'b0;
         r_rd_busy   <= 1'b0;
         r_rd_finish <= 1'b0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               r_rd_finish <= 1'b0;
               r_tick      <= '0;
               if (rd_enable) begin
                  r_state <= ST_SCAN;
               end
            end
            ST_SCAN: begin
               if (!rd_enable) begin
                  r_state <= ST_IDLE;
               end else if (w_commit) begin
                  r_state  <= ST_REQ;
                  r_rd_req <= 1'b1;
                  r_to_cnt <= '0;
               end else if (r_tick < match_threshold) begin
                  r_tick <= r_tick + 1'b1;
               end
            end
            ST_REQ: begin
               if (rd_gnt) begin
                  r_state   <= ST_READ;
                  r_rd_req  <= 1'b0;
                  r_rd_busy <= 1'b1;
               end else if (!rd_enable) begin
                  r_state  <= ST_IDLE;
                  r_rd_req <= 1'b0;
               end else if (w_timeout) begin
                  r_state  <= ST_SCAN;
                  r_rd_req <= 1'b0;
                  r_tick   <= '0;
               end else begin
                  r_to_cnt <= r_to_cnt + 1'b1;
               end
            end
            ST_READ: begin
               if (rd_done) begin
                  r_state     <= ST_FIN;
                  r_rd_busy   <= 1'b0;
                  r_rd_finish <= 1'b1;
               end
            end
            ST_FIN: begin
               r_rd_finish <= 1'b0;
               r_state     <= ST_IDLE;
            end
            default: begin
               r_state     <= ST_IDLE;
               r_rd_req    <= 1'b0;
               r_rd_busy   <= 1'b0;
               r_rd_finish <= 1'b0;
            end
         endcase
      end
   end

   assign rd_req    = r_rd_req;
   assign rd_busy   = r_rd_busy;
   assign rd_finish = r_rd_finish;

endmodule
`default_nettype wire
